counter_bn: RTL

COUNTER_BN -- requirements
Module: counter_bn

---
 rtl/counter_bn_pkg.sv | 17 +
 rtl/counter_bn_sat_counter.sv | 30 +++
 rtl/counter_bn.sv | 104 ++++++++++
 3 files changed

// File: rtl/counter_bn_pkg.sv
// Shared definitions for the counter_bn block: operation encodings and the
// fixed step used by the fast up-count mode.
package counter_bn_pkg;

    localparam int unsigned MODE_W   = 2;
    // Step applied by MODE_UP3.
    localparam int unsigned STEP_UP3 = 3;

    // Operation select carried on bn_mode.
    typedef enum logic [MODE_W-1:0] {
        MODE_UP3  = 2'b00,
        MODE_DN1  = 2'b01,
        MODE_UP1  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : counter_bn_pkg

// File: rtl/counter_bn_sat_counter.sv
// sat_counter: saturating event counter.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears count
//   inc    - add one on this edge (ignored once count is all ones)
//   clr    - synchronous clear, wins over inc
//   count  - current event count, never wraps
module sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    // Count register: clear first, then increment unless saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + CW'(1);
        end
    end

endmodule : sat_counter

// File: rtl/counter_bn.sv
// counter_bn: cascadable NBITS-bit counter with up-by-3, down-by-1, up-by-1
// and parallel-load operations, plus a saturating count of carry events.
//   bn_clk      - sole clock, rising edge
//   bn_reset    - asynchronous active-high reset
//   bn_enable   - count/load enable
//   bn_rci      - ripple-carry-in; stage acts only when bn_enable & bn_rci
//   bn_mode     - 00 up-by-3, 01 down-by-1, 10 up-by-1, 11 load
//   bn_D        - parallel load data
//   bn_clr      - synchronous clear of bn_wrap_cnt
//   bn_Q        - registered count
//   bn_rco      - registered carry/borrow-out pulse, aligned with bn_Q
//   bn_load     - registered load-acknowledge pulse, aligned with bn_Q
//   bn_wrap_cnt - saturating number of bn_rco pulses seen
module counter_bn
    import counter_bn_pkg::*;
#(
    parameter int unsigned NBITS = 4,   // counter width, >= 2
    parameter int unsigned CW    = 8    // wrap-event counter width, >= 1
) (
    input  logic             bn_clk,
    input  logic             bn_reset,
    input  logic             bn_enable,
    input  logic             bn_rci,
    input  logic [1:0]       bn_mode,
    input  logic [NBITS-1:0] bn_D,
    input  logic             bn_clr,
    output logic [NBITS-1:0] bn_Q,
    output logic             bn_rco,
    output logic             bn_load,
    output logic [CW-1:0]    bn_wrap_cnt
);

    // One extra bit so the carry/borrow of the arithmetic survives.
    localparam int unsigned EW = NBITS + 1;

    mode_e            mode_sel;
    logic             active;
    logic [EW-1:0]    ext_res;
    logic [NBITS-1:0] q_nxt;
    logic             rco_nxt;
    logic             load_nxt;

    // Next count and pulse values; an inactive edge holds bn_Q and drops pulses.
    always_comb begin
        mode_sel = mode_e'(bn_mode);
        active   = bn_enable & bn_rci;
        ext_res  = {1'b0, bn_Q};
        q_nxt    = bn_Q;
        rco_nxt  = 1'b0;
        load_nxt = 1'b0;
        if (active) begin
            case (mode_sel)
                MODE_UP3: begin
                    ext_res = {1'b0, bn_Q} + EW'(STEP_UP3);
                    q_nxt   = ext_res[NBITS-1:0];
                    rco_nxt = ext_res[NBITS];
                end
                MODE_DN1: begin
                    // Borrow out of 0 shows up as the extension bit going high.
                    ext_res = {1'b0, bn_Q} - EW'(1);
                    q_nxt   = ext_res[NBITS-1:0];
                    rco_nxt = ext_res[NBITS];
                end
                MODE_UP1: begin
                    ext_res = {1'b0, bn_Q} + EW'(1);
                    q_nxt   = ext_res[NBITS-1:0];
                    rco_nxt = ext_res[NBITS];
                end
                MODE_LOAD: begin
                    q_nxt    = bn_D;
                    load_nxt = 1'b1;
                end
                default: begin
                    q_nxt = bn_Q;
                end
            endcase
        end
    end

    // Count and pulse registers.
    always_ff @(posedge bn_clk or posedge bn_reset) begin
        if (bn_reset) begin
            bn_Q    <= '0;
            bn_rco  <= 1'b0;
            bn_load <= 1'b0;
        end else begin
            bn_Q    <= q_nxt;
            bn_rco  <= rco_nxt;
            bn_load <= load_nxt;
        end
    end

    // Counts edges on which the registered carry pulse is high.
    sat_counter #(
        .CW (CW)
    ) u_wrap_cnt (
        .clk   (bn_clk),
        .reset (bn_reset),
        .inc   (bn_rco),
        .clr   (bn_clr),
        .count (bn_wrap_cnt)
    );

endmodule : counter_bn
